arb2_mux_ctrl: RTL and testbench
================================

# arb2_mux_ctrl

Two-requester round-robin arbiter and sequencer for the shared 32-bit 2:1 datapath multiplexer. It owns the mux select, grants the shared path to one requester at a time, and runs a valid/ready handshake toward the single downstream consumer. A burst limit forces rotation so neither requester can starve the other. The block sits between the two producer units and the consumer, and instantiates the 2:1 word mux internally to produce `out_data`.

## Interface
- `WIDTH`, 32, data word width.
- `MAX_BURST`, 4, accepted beats per ownership before forced rotation; legal range 1..255.

- `clk`  in  1  rising-edge clock; the block uses this one clock only.
- `rst_n`  in  1  synchronous, active-low reset.
- `req0`, `req1`  in  1  requester valid; requester holds `reqN` and `datN` stable until `ackN`.
- `dat0`, `dat1`  in  WIDTH  requester data words.
- `out_ready`  in  1  consumer ready.
- `ack0`, `ack1`  out  1  beat accepted from requester N this cycle (combinational).
- `gnt0`, `gnt1`  out  1  ownership indicators (registered, one-hot or both 0).
- `sel`  out  1  mux select (registered): 0 = `dat0`, 1 = `dat1`.
- `out_valid`  out  1  word on `out_data` is valid.
- `out_data`  out  WIDTH  `sel ? dat1 : dat0`.

## Operation
- State machine (registered): IDLE, OWN0, OWN1. `gnt0` = (state==OWN0), `gnt1` = (state==OWN1).
- `last` register holds the most recent owner and is used for round-robin tie-break.
- `cnt` is a beat counter of width clog2(MAX_BURST+1). It counts accepted beats in the current ownership.
- `out_valid` = (OWN0 & req0) | (OWN1 & req1). `ackN` = gntN & reqN & out_ready.
- `sel` is updated only on entry to OWN0 (0) or OWN1 (1). It holds its value in IDLE.
- Transitions from IDLE:
  - req0 & req1: go to the requester ≠ `last`.
  - Only one request asserted: go to that requester.
  - Neither asserted: stay in IDLE.
  - `cnt` = 0 on entry.
- Transitions from OWNn, with m denoting the other requester:
  - `reqn` = 0 (release): go to OWNm if `reqm`, else IDLE. `cnt` = 0. `last` = n.
  - Accept with `cnt`+1 == MAX_BURST and `reqm` = 1: go to OWNm. `cnt` = 0. `last` = n.
  - Accept with `cnt`+1 == MAX_BURST and `reqm` = 0: stay in OWNn. `cnt` = 0.
  - Accept otherwise: `cnt` increments.
  - `reqn` = 1 with no accept (`out_ready` = 0): hold state and `cnt`.
- Release is checked before the burst limit. Because `reqn` = 0 implies no accept, the two cases never conflict.
- `cnt` never exceeds MAX_BURST−1 and does not wrap.

## Timing
- Reset values (`rst_n` low at a rising edge): state IDLE, `sel` 0, `gnt0`/`gnt1` 0, `cnt` 0, `last` 1 (so requester 0 wins the first tie). `out_valid`, `ack0`, `ack1` are 0 in the cycle after reset, since both derive from gnt.
- Reset mid-burst: the in-flight beat is abandoned and no ack is issued after the reset edge. The requester must keep `req` asserted and is re-arbitrated from IDLE.
- Grant latency: a request seen in IDLE at edge k produces gnt, `sel`, and `out_valid` (if `req` is still high) in cycle k+1. There is no combinational req→gnt path.
- Throughput: one beat per cycle while the owner holds `req` and `out_ready` is high.
- Rotation: OWN0→OWN1 is direct, with no IDLE bubble. The first beat from the new owner can be accepted in the cycle after the last beat of the old owner.
- `out_data` and `out_valid` may change combinationally with `reqN`/`datN`. `ackN` additionally follows `out_ready` combinationally.
- Simultaneous requests in IDLE are resolved by `last` only. Simultaneous release and arrival of the other request goes straight to the other requester.

## Test plan
- Reset, then req0=1 with `dat0`=0xA5A5_0001 and `out_ready`=1. Expect: IDLE in cycle 0; `gnt0`, `sel`=0, and `out_valid` in cycle 1; `ack0` every cycle after; `out_data` = 0xA5A5_0001.
- Hold req0 and req1 both high, `out_ready`=1, MAX_BURST=4. Expect: 4 beats from requester 0, then 4 from requester 1, alternating with no bubble cycles and no starvation over 64 cycles.
- Hold req0 only, with `out_ready` high for 10 cycles. Expect: the block stays in OWN0, `cnt` wraps to 0 at every 4th beat, and there is no IDLE gap.
- In OWN1 with `out_ready`=0 for 5 cycles, then 1. Expect: `out_valid`=1 and `ack1`=0 while stalled, `cnt` frozen, and `out_data` = `dat1` stable; a single `ack1` when ready returns.
- In OWN0, deassert req0 while req1=1. Expect: OWN1 and `sel`=1 at the next edge; `out_valid` follows req1; `last`=0, so in the next tie requester 1 wins.
- Assert `rst_n`=0 for one cycle in the middle of a burst (`cnt`=2). Expect: next cycle IDLE, all outputs 0, `sel`=0; re-grant to requester 0 (`last`=1) one cycle after reset is released.

Source files
------------

// File: rtl/arb2_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arb2_mux_ctrl (+ arb2_word_mux)
// Purpose  : Two-requester round-robin arbiter with burst-limited ownership
//            driving a shared 2:1 word mux toward a valid/ready consumer.
// Revision : 1.0
// ============================================================================

module arb2_word_mux #(
  parameter int WIDTH = 32
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

module arb2_mux_ctrl #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dat0,
  input  logic [WIDTH-1:0] dat1,
  input  logic             out_ready,
  output logic             ack0,
  output logic             ack1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state_q;
  logic            sel_q;
  logic            last_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_inc;
  logic            burst_done;

  assign gnt0       = (state_q == OWN0);
  assign gnt1       = (state_q == OWN1);
  assign sel        = sel_q;
  assign ack0       = gnt0 & req0 & out_ready;
  assign ack1       = gnt1 & req1 & out_ready;
  assign out_valid  = (gnt0 & req0) | (gnt1 & req1);
  assign cnt_inc    = cnt_q + CW'(1);
  assign burst_done = (cnt_inc == CW'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // On a tie the requester that did not own the path last wins
          if (req0 && (!req1 || last_q)) begin
            state_q <= OWN0;
            sel_q   <= 1'b0;
          end else if (req1) begin
            state_q <= OWN1;
            sel_q   <= 1'b1;
          end
        end
        OWN0: begin
          if (!req0) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
            if (req1) begin
              state_q <= OWN1;
              sel_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (ack0) begin
            if (burst_done) begin
              cnt_q <= '0;
              if (req1) begin
                state_q <= OWN1;
                sel_q   <= 1'b1;
                last_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        OWN1: begin
          if (!req1) begin
            cnt_q  <= '0;
            last_q <= 1'b1;
            if (req0) begin
              state_q <= OWN0;
              sel_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else if (ack1) begin
            if (burst_done) begin
              cnt_q <= '0;
              if (req0) begin
                state_q <= OWN0;
                sel_q   <= 1'b0;
                last_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  arb2_word_mux #(.WIDTH(WIDTH)) u_mux (
    .sel_i (sel_q),
    .a_i   (dat0),
    .b_i   (dat1),
    .y_o   (out_data)
  );
endmodule
`default_nettype wire

// File: tb/tb_arb2_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb2_mux_ctrl
// Purpose  : Directed self-checking bench for arb2_mux_ctrl.
// Revision : 1.0
// ============================================================================
module tb_arb2_mux_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] dat0, dat1;
  logic        out_ready;
  logic        ack0, ack1, gnt0, gnt1, sel, out_valid;
  logic [31:0] out_data;

  int vectors     = 0;
  int miscompares = 0;
  int beats0, beats1, owner;

  always #5 clk = ~clk;

  arb2_mux_ctrl #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .dat0      (dat0),
    .dat1      (dat1),
    .out_ready (out_ready),
    .ack0      (ack0),
    .ack1      (ack1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    dat0 = '0; dat1 = '0; out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_sel", sel, 0);
    check("rst_valid", out_valid, 0);
    check("rst_cnt", dut.cnt_q, 0);
    check("rst_last", dut.last_q, 1);

    // Single requester: grant one cycle later, then a beat every cycle
    req0 = 1'b1; dat0 = 32'hA5A5_0001; out_ready = 1'b1;
    #1;
    check("t1_c0_gnt0", gnt0, 0);
    check("t1_c0_valid", out_valid, 0);
    check("t1_c0_ack0", ack0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_gnt0", gnt0, 1);
      check("t1_gnt1", gnt1, 0);
      check("t1_sel", sel, 0);
      check("t1_valid", out_valid, 1);
      check("t1_ack0", ack0, 1);
      check("t1_data", out_data, 32'hA5A5_0001);
      check("t1_cnt", dut.cnt_q, i % 4);
    end

    // Release of owner 0 while req1 waits: direct hand-over
    req0 = 1'b0; req1 = 1'b1; dat1 = 32'h5A5A_0002;
    #1;
    check("t5_rel_valid", out_valid, 0);
    check("t5_rel_ack0", ack0, 0);
    check("t5_rel_ack1", ack1, 0);
    tick();
    check("t5_gnt1", gnt1, 1);
    check("t5_gnt0", gnt0, 0);
    check("t5_sel", sel, 1);
    check("t5_valid", out_valid, 1);
    check("t5_ack1", ack1, 1);
    check("t5_data", out_data, 32'h5A5A_0002);
    check("t5_last", dut.last_q, 0);
    check("t5_cnt", dut.cnt_q, 0);
    req1 = 1'b0;
    tick();
    check("t5_idle_gnt1", gnt1, 0);
    check("t5_idle_sel_hold", sel, 1);
    check("t5_idle_last", dut.last_q, 1);
    req0 = 1'b1;
    tick();
    check("t5_own0_gnt0", gnt0, 1);
    req0 = 1'b0;
    tick();
    check("t5_idle2_gnt0", gnt0, 0);
    check("t5_idle2_last", dut.last_q, 0);
    req0 = 1'b1; req1 = 1'b1; dat0 = 32'h1111_0000; dat1 = 32'h2222_0000;
    #1;
    check("t5_nocomb_gnt0", gnt0, 0);
    check("t5_nocomb_gnt1", gnt1, 0);
    tick();
    check("t5_tie_gnt1", gnt1, 1);
    check("t5_tie_gnt0", gnt0, 0);
    check("t5_tie_sel", sel, 1);
    check("t5_tie_data", out_data, 32'h2222_0000);

    // Reset out of OWN1, then a stalled beat in OWN1
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b1; out_ready = 1'b0; dat1 = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1;
    #1;
    check("t4_rst_gnt1", gnt1, 0);
    check("t4_rst_sel", sel, 0);
    check("t4_rst_valid", out_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_gnt1", gnt1, 1);
      check("t4_stall_valid", out_valid, 1);
      check("t4_stall_ack1", ack1, 0);
      check("t4_stall_data", out_data, 32'hDEAD_BEEF);
      check("t4_stall_cnt", dut.cnt_q, 0);
      if (i < 4) tick();
    end
    out_ready = 1'b1;
    #1;
    check("t4_ready_ack1", ack1, 1);
    tick();
    req1 = 1'b0;
    #1;
    check("t4_post_ack1", ack1, 0);
    check("t4_post_valid", out_valid, 0);
    check("t4_post_cnt", dut.cnt_q, 1);
    tick();
    check("t4_idle_gnt1", gnt1, 0);

    // Both requesting: 4 beats each, alternating, no bubbles
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    dat0 = 32'h0000_00C0; dat1 = 32'h0000_00C1; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    check("t2_idle_gnt0", gnt0, 0);
    check("t2_idle_gnt1", gnt1, 0);
    tick();
    beats0 = 0; beats1 = 0;
    for (int j = 0; j < 64; j++) begin
      owner = (j / 4) % 2;
      check("t2_gnt0", gnt0, (owner == 0) ? 1 : 0);
      check("t2_gnt1", gnt1, (owner == 1) ? 1 : 0);
      check("t2_sel", sel, owner);
      check("t2_ack0", ack0, (owner == 0) ? 1 : 0);
      check("t2_ack1", ack1, (owner == 1) ? 1 : 0);
      check("t2_data", out_data, (owner == 1) ? 32'h0000_00C1 : 32'h0000_00C0);
      if (ack0) beats0++;
      if (ack1) beats1++;
      tick();
    end
    check("t2_beats0", beats0, 32);
    check("t2_beats1", beats1, 32);

    // Reset in the middle of a burst
    rst_n = 1'b0; req1 = 1'b0; req0 = 1'b1; dat0 = 32'h0BAD_F00D;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("t6_mid_gnt0", gnt0, 1);
    check("t6_mid_cnt", dut.cnt_q, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_rst_gnt0", gnt0, 0);
    check("t6_rst_gnt1", gnt1, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ack0", ack0, 0);
    check("t6_rst_sel", sel, 0);
    check("t6_rst_cnt", dut.cnt_q, 0);
    check("t6_rst_last", dut.last_q, 1);
    tick();
    check("t6_regrant_gnt0", gnt0, 1);
    check("t6_regrant_ack0", ack0, 1);
    check("t6_regrant_data", out_data, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
